// File: rtl/alu_cmd_sequencer.sv
// Command sequencer: a 4-deep command FIFO feeding an IDLE/EXEC/RESP FSM that drives an external ALU.
// Optional: define ALU_CMD_SEQ_ZERO_FLAG_EN to add the registered res_zero output.
module alu_cmd_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic [1:0] alu_op,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_res,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
  output logic       res_zero,
`endif
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [10:0] r_fifo_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;

  logic [7:0]  r_acc;
  logic [1:0]  r_alu_op;
  logic [7:0]  r_alu_b;
  logic [7:0]  r_res_data;

  logic        w_push;
  logic        w_pop;
  logic        w_fifo_nempty;
  logic [10:0] w_head;
  logic        w_res_wr;
  logic [7:0]  w_res_val;

  // FIFO entry layout: {load, op[1:0], data[7:0]}
  assign cmd_ready     = (r_count < 3'd4);
  assign w_push        = cmd_valid && cmd_ready;
  assign w_fifo_nempty = (r_count != 3'd0);
  assign w_head        = r_fifo_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= {cmd_load, cmd_op, cmd_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_nempty) begin
          w_pop        = 1'b1;
          w_state_next = w_head[10] ? ST_RESP : ST_EXEC;
        end
      end
      ST_EXEC: w_state_next = ST_RESP;
      ST_RESP: if (res_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Accumulator and result register are written together: on a load pop or at the end of EXEC.
  always_comb begin
    w_res_wr  = 1'b0;
    w_res_val = alu_res;
    if (w_pop && w_head[10]) begin
      w_res_wr  = 1'b1;
      w_res_val = w_head[7:0];
    end else if (r_state == ST_EXEC) begin
      w_res_wr  = 1'b1;
      w_res_val = alu_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= 8'h00;
      r_alu_op   <= 2'd0;
      r_alu_b    <= 8'h00;
      r_res_data <= 8'h00;
    end else begin
      if (w_pop && !w_head[10]) begin
        r_alu_op <= w_head[9:8];
        r_alu_b  <= w_head[7:0];
      end
      if (w_res_wr) begin
        r_acc      <= w_res_val;
        r_res_data <= w_res_val;
      end
    end
  end

`ifdef ALU_CMD_SEQ_ZERO_FLAG_EN
  logic r_res_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_res_zero <= 1'b0;
    else if (w_res_wr) r_res_zero <= (w_res_val == 8'h00);
  end

  assign res_zero = r_res_zero;
`endif

  assign alu_op    = r_alu_op;
  assign alu_a     = r_acc;
  assign alu_b     = r_alu_b;
  assign res_data  = r_res_data;
  assign res_valid = (r_state == ST_RESP);
  assign busy      = (r_state != ST_IDLE) || w_fifo_nempty;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous active-low reset; asserting low clears all state immediately, release synchronous to clk.
REQ-003 cmd_valid  in  1  upstream command present.
REQ-004 cmd_ready  out  1  command FIFO can accept; equals (fifo count < 4).
REQ-005 cmd_load  in  1  1 = load accumulator with cmd_data; 0 = ALU operation.
REQ-006 cmd_op  in  2  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 NOT; ignored when cmd_load=1.
REQ-007 cmd_data  in  8  load value or ALU operand B.
REQ-008 alu_op  out  2  registered opcode driven to ALU.
REQ-009 alu_a  out  8  ALU operand A; continuously equals accumulator register.
REQ-010 alu_b  out  8  registered ALU operand B.
REQ-011 alu_res  in  8  combinational ALU result.
REQ-012 res_valid  out  1  result beat present.
REQ-013 res_ready  in  1  downstream accepts result.
REQ-014 res_data  out  8  registered result.
REQ-015 busy  out  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-016 Command FIFO SHALL be 4 entries x 11 bits {load, op, data}, push on cmd_valid&&cmd_ready, in-order pop.
REQ-017 Simultaneous push and pop SHALL leave count unchanged; push with count=4 SHALL NOT occur (cmd_ready low); pointers wrap modulo 4.
REQ-018 FSM states SHALL be IDLE, EXEC, RESP.
REQ-019 IDLE: if FIFO non-empty, pop at edge; load cmd -> acc<=data, res_data<=data, go RESP; ALU cmd -> alu_op<=op, alu_b<=data, go EXEC; else stay.
REQ-020 EXEC (exactly one cycle): acc<=alu_res, res_data<=alu_res, go RESP.
REQ-021 RESP: res_valid=1; res_data, acc held stable; on res_ready go IDLE, else stay.
REQ-022 Latency: entry written at edge k into empty FIFO -> popped at edge k+1; load res_valid high after edge k+1; ALU res_valid high after edge k+2.
REQ-023 res_valid SHALL be high only in RESP; one result beat per command, in command order.
REQ-024 Block SHALL apply no arithmetic itself: results are 8-bit ALU values, wrap-around (e.g. 0x00-0x01=0xFF) passed unmodified; AND/NOT yield logical 0x00/0x01 as the ALU produces.
REQ-025 FIFO SHALL continue accepting commands in EXEC and RESP until full.
REQ-026 res_ready while res_valid=0 SHALL be ignored.

Reset
REQ-027 On rst_n low: acc=0x00, alu_op=0, alu_b=0x00, res_data=0x00, res_valid=0, FIFO empty (cmd_ready=1), busy=0, FSM=IDLE.
REQ-028 Reset mid-operation SHALL discard in-flight command and all FIFO contents; no result beat after release.

Configuration
REQ-029 Macro ALU_CMD_SEQ_ZERO_FLAG_EN defined: extra output res_zero (out, 1) registered with res_data, equal to (value written to res_data == 0x00), reset 0.
REQ-030 Macro undefined: res_zero port and its register absent; all other behaviour identical.

Verification
REQ-031 Reset: hold rst_n=0 -> acc=0x00, res_valid=0, cmd_ready=1, busy=0, alu_op=0.
REQ-032 Load 0x05 then ADD 0x03, res_ready=1 -> results 0x05 then 0x08; ADD res_valid exactly 2 edges after pop-eligible cycle.
REQ-033 acc=0x08, SUB 0x09 -> res_data=0xFF, acc=0xFF, res_zero=0 (flag build).
REQ-034 acc=0x05, AND 0x03 -> 0x01; then NOT -> 0x00, res_zero=1 (flag build).
REQ-035 res_ready=0, push 6 commands back-to-back -> 5 accepted (1 popped, 4 queued), cmd_ready=0 on 6th; release res_ready -> 5 results in order.
REQ-036 Assert rst_n low during EXEC with 2 commands queued -> outputs cleared same cycle, no res_valid after release, cmd_ready=1.
